// File: rtl/nios_core_mult_pkg.sv
// nios_core_mult_pkg
//   Shared constants and payload types for the multiply combine pipeline.
//   TAG_W_DEFAULT : default width of the destination-register tag.
//   MULT_COMB_LAT : cycles from an accepted input to out_valid when unstalled.
//   mult_stage_t  : stage payload (32-bit result plus tag) at the default width.
//   mid_sum       : cross-term sum; only the low product halves reach bits [31:16].
package nios_core_mult_pkg;

  localparam int unsigned TAG_W_DEFAULT = 5;
  localparam int unsigned MULT_COMB_LAT = 2;

  typedef struct packed {
    logic [31:0]              result;
    logic [TAG_W_DEFAULT-1:0] tag;
  } mult_stage_t;

  function automatic logic [15:0] mid_sum(input logic [31:0] p2, input logic [31:0] p3);
    return p2[15:0] + p3[15:0];
  endfunction

endpackage

// File: rtl/nios_core_mult_pipe_reg.sv
// nios_core_mult_pipe_reg
//   One valid/ready register slice. Loads whenever it is empty or its consumer
//   accepts, so a full chain of slices sustains one transfer per cycle.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (clears valid and data)
//     flush        : drop the held entry and anything offered this cycle
//     in_valid_i   / in_ready_o  / in_data_i  : upstream handshake and payload
//     out_valid_o  / out_ready_i / out_data_o : downstream handshake and payload
//   Parameter T : payload type.
module nios_core_mult_pipe_reg
  import nios_core_mult_pkg::*;
#(
  parameter type T = mult_stage_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;
  logic load;

  always_comb begin
    load    = !valid_q || out_ready_i;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid_i;
      // Data only moves with a real entry so a bubble never disturbs the outputs.
      if (in_valid_i) data_d = in_data_i;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready_o  = load;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/nios_core_nios2_gen2_cpu_mult_combine.sv
// nios_core_nios2_gen2_cpu_mult_combine
//   Combines three 16x16 partial products into the low 32 bits of a 32x32
//   product over two register stages (A: p1 + cross-term sum, B: final add).
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//     in_valid / in_ready     : input handshake (in_ready depends only on state and out_ready)
//     in_p1, in_p2, in_p3     : lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2)
//     in_tag                  : destination tag, travels with the product
//     flush                   : squash all in-flight operations at the next edge
//     out_valid / out_ready   : output handshake
//     out_result, out_tag     : low 32 bits of src1*src2 and its tag
//     busy                    : any stage holds valid data
//     mul_count               : output transfer count (only with NIOS_MULT_CNT_EN)
//   Build option: define NIOS_MULT_CNT_EN to add the mul_count port and counter.
module nios_core_nios2_gen2_cpu_mult_combine
  import nios_core_mult_pkg::*;
#(
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef NIOS_MULT_CNT_EN
  ,
  output logic [31:0]      mul_count
`endif
);

  typedef struct packed {
    logic [15:0]      mid;
    logic [31:0]      p1;
    logic [TAG_W-1:0] tag;
  } stage_a_t;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
  } stage_b_t;

  stage_a_t a_in, a_q;
  stage_b_t b_in, b_q;
  logic     a_valid;
  logic     b_in_ready;

  always_comb begin
    a_in.mid = mid_sum(in_p2, in_p3);
    a_in.p1  = in_p1;
    a_in.tag = in_tag;
  end

  always_comb begin
    b_in.result = a_q.p1 + {a_q.mid, 16'h0000};
    b_in.tag    = a_q.tag;
  end

  nios_core_mult_pipe_reg #(
    .T (stage_a_t)
  ) u_stage_a (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (a_in),
    .out_valid_o (a_valid),
    .out_ready_i (b_in_ready),
    .out_data_o  (a_q)
  );

  nios_core_mult_pipe_reg #(
    .T (stage_b_t)
  ) u_stage_b (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid_i  (a_valid),
    .in_ready_o  (b_in_ready),
    .in_data_i   (b_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (b_q)
  );

  assign out_result = b_q.result;
  assign out_tag    = b_q.tag;
  assign busy       = a_valid || out_valid;

`ifdef NIOS_MULT_CNT_EN
  // Counts delivered results; a handshake in a flush cycle still counts.
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign mul_count = cnt_q;
`endif

endmodule
